// File: rtl/medidor_distancia_bcd.sv
// -----------------------------------------------------------------------------
// medidor_distancia_bcd
// Ultrasonic echo-width meter. A start request arms the block; the width of
// the next echo pulse is converted to distance (cm or inch) with rounding and
// accumulated directly in a D-digit BCD counter.
//
// Parameters
//   R_CM    clocks per cm of echo width (>= 2)
//   R_IN    clocks per inch of echo width (>= 2)
//   D       number of BCD digits in the result (1..6)
//   TIMEOUT maximum clocks spent waiting for / measuring the echo
//
// Ports
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   mede      start request (honoured only when idle or finished)
//   pulso     echo pulse, already synchronous to clock
//   unidade   0 = cm, 1 = inch; latched when a measurement starts
//   medida    BCD result, digit 0 in [3:0]
//   pronto    one-cycle strobe when medida is updated
//   ocupado   measurement in progress
//   timeout   last measurement expired (result forced to all 9s)
//   saturado  last count clipped at all 9s
//   db_estado debug view of the state code
// -----------------------------------------------------------------------------
module medidor_distancia_bcd #(
  parameter int R_CM    = 2941,
  parameter int R_IN    = 7462,
  parameter int D       = 3,
  parameter int TIMEOUT = 1500000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           mede,
  input  logic           pulso,
  input  logic           unidade,
  output logic [4*D-1:0] medida,
  output logic           pronto,
  output logic           ocupado,
  output logic           timeout,
  output logic           saturado,
  output logic [2:0]     db_estado
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    MEDINDO  = 3'd2,
    ARMAZENA = 3'd3,
    FINAL    = 3'd4
  } estado_t;

  localparam int R_MAX = (R_CM > R_IN) ? R_CM : R_IN;
  localparam int PW    = $clog2(R_MAX);
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] CM_HALF = PW'(R_CM / 2);
  localparam logic [PW-1:0] CM_LAST = PW'(R_CM - 1);
  localparam logic [PW-1:0] IN_HALF = PW'(R_IN / 2);
  localparam logic [PW-1:0] IN_LAST = PW'(R_IN - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  // All digits at 9: saturation ceiling and timeout result.
  function automatic logic [4*D-1:0] bcd_all9();
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decimal increment with ripple carry; caller guards the all-9s case.
  function automatic logic [4*D-1:0] bcd_inc(input logic [4*D-1:0] v);
    logic [4*D-1:0] r;
    logic           c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  localparam logic [4*D-1:0] BCD_MAX = bcd_all9();

  estado_t        estado_r;
  estado_t        prox_s;
  logic           pulso_prev_r;
  logic           unit_r;
  logic [PW-1:0]  presc_r;
  logic [TW-1:0]  timer_r;
  logic [4*D-1:0] bcd_r;
  logic [4*D-1:0] medida_r;
  logic           pronto_r;
  logic           ocupado_r;
  logic           timeout_r;
  logic           saturado_r;

  logic           start_s;
  logic           begin_s;
  logic           expire_s;
  logic           count_s;
  logic           ocup_s;
  logic [PW-1:0]  half_s;
  logic [PW-1:0]  last_s;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    prox_s   = estado_r;
    start_s  = 1'b0;
    begin_s  = 1'b0;
    expire_s = 1'b0;
    count_s  = 1'b0;
    if (unit_r) begin
      half_s = IN_HALF;
      last_s = IN_LAST;
    end else begin
      half_s = CM_HALF;
      last_s = CM_LAST;
    end
    case (estado_r)
      INICIAL, FINAL: begin
        if (mede) begin
          prox_s  = ESPERA;
          start_s = 1'b1;
        end else begin
          prox_s = estado_r;
        end
      end
      ESPERA: begin
        // Timer expiry outranks a coincident echo edge.
        if (timer_r == T_LAST) begin
          prox_s   = ARMAZENA;
          expire_s = 1'b1;
        end else if (pulso && !pulso_prev_r) begin
          prox_s  = MEDINDO;
          begin_s = 1'b1;
        end else begin
          prox_s = ESPERA;
        end
      end
      MEDINDO: begin
        if (timer_r == T_LAST) begin
          prox_s   = ARMAZENA;
          expire_s = 1'b1;
        end else if (!pulso) begin
          prox_s = ARMAZENA;
        end else begin
          prox_s  = MEDINDO;
          // Counting at mid-ratio rounds the conversion to nearest unit.
          count_s = (presc_r == half_s);
        end
      end
      ARMAZENA: prox_s = FINAL;
      default:  prox_s = INICIAL;
    endcase
    ocup_s = (prox_s == ESPERA) || (prox_s == MEDINDO) || (prox_s == ARMAZENA);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r     <= INICIAL;
      pulso_prev_r <= 1'b0;
      unit_r       <= 1'b0;
      presc_r      <= '0;
      timer_r      <= '0;
      bcd_r        <= '0;
      medida_r     <= '0;
      pronto_r     <= 1'b0;
      ocupado_r    <= 1'b0;
      timeout_r    <= 1'b0;
      saturado_r   <= 1'b0;
    end else begin
      estado_r     <= prox_s;
      pulso_prev_r <= pulso;
      pronto_r     <= (prox_s == ARMAZENA);
      ocupado_r    <= ocup_s;
      if (start_s) begin
        unit_r     <= unidade;
        presc_r    <= '0;
        timer_r    <= '0;
        bcd_r      <= '0;
        timeout_r  <= 1'b0;
        saturado_r <= 1'b0;
      end else if (begin_s) begin
        // The edge cycle itself is the first high clock (prescaler 0).
        timer_r <= '0;
        presc_r <= PW'(1);
      end else if (expire_s) begin
        timeout_r <= 1'b1;
        bcd_r     <= BCD_MAX;
      end else if (estado_r == MEDINDO && pulso) begin
        timer_r <= timer_r + TW'(1);
        if (presc_r == last_s) begin
          presc_r <= '0;
        end else begin
          presc_r <= presc_r + PW'(1);
        end
        if (count_s) begin
          if (bcd_r == BCD_MAX) begin
            saturado_r <= 1'b1;
          end else begin
            bcd_r <= bcd_inc(bcd_r);
          end
        end
      end else if (estado_r == ESPERA || estado_r == MEDINDO) begin
        timer_r <= timer_r + TW'(1);
      end
      if (prox_s == ARMAZENA) begin
        if (expire_s) begin
          medida_r <= BCD_MAX;
        end else begin
          medida_r <= bcd_r;
        end
      end
    end
  end

  assign medida    = medida_r;
  assign pronto    = pronto_r;
  assign ocupado   = ocupado_r;
  assign timeout   = timeout_r;
  assign saturado  = saturado_r;
  assign db_estado = estado_r;

endmodule

// File: tb/tb_medidor_distancia_bcd.sv
// -----------------------------------------------------------------------------
// tb_medidor_distancia_bcd
// Directed bench for medidor_distancia_bcd with R_CM=10, R_IN=25, TIMEOUT=200.
// Two instances share all inputs: dut (D=3) and dut1 (D=1, saturation case).
// -----------------------------------------------------------------------------
module tb_medidor_distancia_bcd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mede = 1'b0;
  logic        pulso = 1'b0;
  logic        unidade = 1'b0;
  logic [11:0] medida;
  logic        pronto, ocupado, timeout, saturado;
  logic [2:0]  db_estado;
  logic [3:0]  medida1;
  logic        pronto1, ocupado1, timeout1, saturado1;
  logic [2:0]  db_estado1;

  int checks = 0;
  int failures = 0;

  // Values captured by run_pulse.
  int          n_pronto;
  logic [11:0] cap3;
  logic [3:0]  cap1;

  medidor_distancia_bcd #(.R_CM(10), .R_IN(25), .D(3), .TIMEOUT(200)) dut (
    .clock(clock), .reset(reset), .mede(mede), .pulso(pulso), .unidade(unidade),
    .medida(medida), .pronto(pronto), .ocupado(ocupado), .timeout(timeout),
    .saturado(saturado), .db_estado(db_estado)
  );

  medidor_distancia_bcd #(.R_CM(10), .R_IN(25), .D(1), .TIMEOUT(200)) dut1 (
    .clock(clock), .reset(reset), .mede(mede), .pulso(pulso), .unidade(unidade),
    .medida(medida1), .pronto(pronto1), .ocupado(ocupado1), .timeout(timeout1),
    .saturado(saturado1), .db_estado(db_estado1)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start a measurement, drive an echo of len clocks, then wait for the result.
  task automatic run_pulse(input int len, input logic unit, input logic flip,
                           input logic mid_mede);
    n_pronto = 0;
    cap3     = 12'hxxx;
    cap1     = 4'hx;
    reset    = 1'b0;
    unidade  = unit;
    mede     = 1'b1;
    step();
    mede = 1'b0;
    step();
    step();
    for (int i = 0; i < len; i++) begin
      pulso = 1'b1;
      mede  = (mid_mede && i == len / 2);
      if (flip && i == len / 2) unidade = ~unidade;
      step();
    end
    mede  = 1'b0;
    pulso = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pronto) begin
        n_pronto++;
        cap3 = medida;
        cap1 = medida1;
      end
      if (db_estado == 3'd4 && n_pronto > 0) break;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (pronto) n_pronto++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mede  = 1'b1;
    pulso = 1'b1;
    step();
    step();
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
    checks++; if (medida !== 12'h000) begin failures++; $display("FAIL reset_medida got=%h exp=000", medida); end
    checks++; if ({pronto, ocupado, timeout, saturado} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {pronto, ocupado, timeout, saturado}); end
    mede  = 1'b0;
    pulso = 1'b0;
    step();
  endtask

  task automatic test_short();
    run_pulse(6, 1'b0, 1'b0, 1'b0);
    checks++; if (n_pronto !== 1) begin failures++; $display("FAIL short6_pronto got=%0d exp=1", n_pronto); end
    checks++; if (cap3 !== 12'h001) begin failures++; $display("FAIL short6_medida got=%h exp=001", cap3); end
    checks++; if (db_estado !== 3'd4) begin failures++; $display("FAIL short6_final got=%0d exp=4", db_estado); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL short6_ocupado got=%b exp=0", ocupado); end
    run_pulse(5, 1'b0, 1'b0, 1'b0);
    checks++; if (n_pronto !== 1) begin failures++; $display("FAIL short5_pronto got=%0d exp=1", n_pronto); end
    checks++; if (cap3 !== 12'h000) begin failures++; $display("FAIL short5_medida got=%h exp=000", cap3); end
    checks++; if (medida !== 12'h000) begin failures++; $display("FAIL short5_hold got=%h exp=000", medida); end
  endtask

  task automatic test_long();
    run_pulse(126, 1'b0, 1'b0, 1'b0);
    checks++; if (cap3 !== 12'h013) begin failures++; $display("FAIL long_medida got=%h exp=013", cap3); end
    checks++; if (saturado !== 1'b0) begin failures++; $display("FAIL long_saturado got=%b exp=0", saturado); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL long_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_unit_latch();
    run_pulse(63, 1'b1, 1'b1, 1'b0);
    checks++; if (cap3 !== 12'h003) begin failures++; $display("FAIL inch_medida got=%h exp=003", cap3); end
    unidade = 1'b0;
  endtask

  task automatic test_timeout();
    run_pulse(0, 1'b0, 1'b0, 1'b0);
    checks++; if (n_pronto !== 1) begin failures++; $display("FAIL tmo_pronto got=%0d exp=1", n_pronto); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", timeout); end
    checks++; if (cap3 !== 12'h999) begin failures++; $display("FAIL tmo_medida got=%h exp=999", cap3); end
    run_pulse(6, 1'b0, 1'b0, 1'b0);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", timeout); end
    checks++; if (cap3 !== 12'h001) begin failures++; $display("FAIL tmo_after_medida got=%h exp=001", cap3); end
  endtask

  task automatic test_saturate();
    run_pulse(150, 1'b0, 1'b0, 1'b1);
    checks++; if (n_pronto !== 1) begin failures++; $display("FAIL sat_pronto got=%0d exp=1", n_pronto); end
    checks++; if (cap1 !== 4'h9) begin failures++; $display("FAIL sat_medida1 got=%h exp=9", cap1); end
    checks++; if (saturado1 !== 1'b1) begin failures++; $display("FAIL sat_flag1 got=%b exp=1", saturado1); end
    checks++; if (cap3 !== 12'h015) begin failures++; $display("FAIL sat_medida3 got=%h exp=015", cap3); end
    checks++; if (saturado !== 1'b0) begin failures++; $display("FAIL sat_flag3 got=%b exp=0", saturado); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen    = 0;
    unidade = 1'b0;
    mede    = 1'b1;
    step();
    mede  = 1'b0;
    pulso = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (db_estado !== 3'd2) begin failures++; $display("FAIL mid_in_medindo got=%0d exp=2", db_estado); end
    reset = 1'b1;
    step();
    checks++; if (db_estado !== 3'd0) begin failures++; $display("FAIL mid_estado got=%0d exp=0", db_estado); end
    checks++; if (medida !== 12'h000) begin failures++; $display("FAIL mid_medida got=%h exp=000", medida); end
    checks++; if ({pronto, ocupado, timeout, saturado} !== 4'b0000) begin failures++; $display("FAIL mid_flags got=%b exp=0000", {pronto, ocupado, timeout, saturado}); end
    reset = 1'b0;
    pulso = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pronto) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_pronto got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_unit_latch();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/medidor_distancia_bcd.md
MEDIDOR_DISTANCIA_BCD -- requirements
Module: medidor_distancia_bcd

Interface
REQ-001 SHALL have parameter R_CM, default 2941: clocks per cm of echo width; must be >= 2.
REQ-002 SHALL have parameter R_IN, default 7462: clocks per inch of echo width; must be >= 2.
REQ-003 SHALL have parameter D, default 3: number of BCD output digits, 1..6.
REQ-004 SHALL have parameter TIMEOUT, default 1500000: maximum clocks per measurement phase.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port mede, input, 1 bit: start request, sampled in INICIAL and FINAL only.
REQ-008 SHALL have port pulso, input, 1 bit: echo pulse, already synchronous to clock.
REQ-009 SHALL have port unidade, input, 1 bit: 0 selects cm (R_CM), 1 selects inch (R_IN); latched at start.
REQ-010 SHALL have port medida, output, 4*D bits: result, digit 0 in bits [3:0], each nibble 0..9.
REQ-011 SHALL have port pronto, output, 1 bit: one-cycle pulse when medida is updated.
REQ-012 SHALL have port ocupado, output, 1 bit: high in ESPERA, MEDINDO and ARMAZENA.
REQ-013 SHALL have port timeout, output, 1 bit: last measurement timed out; held until next start.
REQ-014 SHALL have port saturado, output, 1 bit: last count clipped at all-9s; held until next start.
REQ-015 SHALL have port db_estado, output, 3 bits: state code, INICIAL=0, ESPERA=1, MEDINDO=2, ARMAZENA=3, FINAL=4.

Function
REQ-016 SHALL implement FSM states INICIAL, ESPERA, MEDINDO, ARMAZENA, FINAL.
REQ-017 SHALL go INICIAL->ESPERA or FINAL->ESPERA when mede=1; on that edge it latches unidade, clears the prescaler, BCD counter, phase timer, timeout and saturado.
REQ-018 SHALL ignore mede in ESPERA, MEDINDO and ARMAZENA.
REQ-019 SHALL in ESPERA go to MEDINDO on a pulso rising edge (pulso=1 with the previous-cycle sample=0); a pulso already high at entry SHALL NOT count until it falls and rises again.
REQ-020 SHALL in MEDINDO, each cycle with pulso=1, advance the prescaler 0..R-1 with wrap (R = latched unit ratio; the first high cycle holds value 0).
REQ-021 SHALL increment the BCD counter in every MEDINDO cycle where pulso=1 and prescaler == R/2 (integer division), giving rounded conversion: pulse of L clocks yields floor((L-1-R/2)/R)+1 if L-1 >= R/2, else 0.
REQ-022 SHALL saturate the BCD counter at all digits 9: no wrap, saturado set, counting otherwise continues.
REQ-023 SHALL go MEDINDO->ARMAZENA on the first cycle with pulso=0.
REQ-024 SHALL in ARMAZENA load medida from the BCD counter, pulse pronto for that one cycle, then go to FINAL.
REQ-025 SHALL count the phase timer in ESPERA and MEDINDO (cleared on ESPERA->MEDINDO); on reaching TIMEOUT-1 it SHALL set timeout, force the BCD counter to all 9s and go to ARMAZENA.
REQ-026 SHALL apply the timeout priority rule: if timeout expiry and the pulso transition occur in the same cycle, timeout wins.
REQ-027 SHALL hold medida stable outside ARMAZENA; the reported unit follows the unidade value latched at start, not the live input.
REQ-028 SHALL size the prescaler to ceil(log2(max(R_CM,R_IN))) bits and the timer to ceil(log2(TIMEOUT)) bits.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, enter INICIAL with medida=0, pronto=0, ocupado=0, timeout=0, saturado=0, db_estado=0, and all counters and the latched unit cleared.
REQ-030 SHALL abort any measurement when reset is asserted mid-operation, with no pronto pulse.
REQ-031 SHALL give reset priority over mede and pulso in the same cycle.

Verification (R_CM=10, R_IN=25, D=3, TIMEOUT=200)
REQ-032 SHALL cover: reset, mede, unidade=0, pulso high for 6 clocks -> one pronto, medida=0x001; for 5 clocks -> medida=0x000.
REQ-033 SHALL cover: unidade=0, pulso 126 clocks -> medida=0x013, saturado=0, timeout=0.
REQ-034 SHALL cover: unidade=1 latched at start and toggled to 0 mid-pulse, pulso 63 clocks -> medida=0x003 (inch ratio used).
REQ-035 SHALL cover: no pulso after mede -> pronto at timer expiry, timeout=1, medida=0x999; then a valid measurement clears timeout.
REQ-036 SHALL cover: D=1, pulso 150 clocks -> medida=0x9, saturado=1; also mede pulses during MEDINDO are ignored.
REQ-037 SHALL cover: reset asserted in MEDINDO -> next cycle db_estado=0, all outputs 0, no pronto.
